// File: rtl/note_period_meter.sv
// Recovers the half-period note word from an 8-bit sampled tone. The chain is a
// hysteresis slicer, an edge detector, a saturating period counter and a stability filter.
module note_period_meter #(
    parameter logic [7:0]  HI_THR   = 8'd160,
    parameter logic [7:0]  LO_THR   = 8'd96,
    parameter logic [26:0] MIN_HALF = 27'd2,
    parameter logic [26:0] TOL      = 27'd1,
    parameter int unsigned STABLE_N = 4,
    parameter logic [26:0] TIMEOUT  = 27'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sample_in,
    output logic [26:0] note,
    output logic        note_valid,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [3:0] STABLE_W = 4'(STABLE_N);

    state_t        state_q, state_d;
    logic [7:0]    sample_q;
    logic          level_q, level_d;
    logic [26:0]   cnt_q, cnt_d;
    logic [26:0]   cand_q, cand_d;
    logic [3:0]    match_q, match_d;
    logic [26:0]   note_q, note_d;
    logic          nv_q, nv_d;
    logic          locked_q, locked_d;

    logic          edge_w;
    logic          glitch_w;
    logic          within_w;
    logic          cnt_sat_w;
    logic signed [27:0] diff_w;
    logic [27:0]   absdiff_w;
    logic [26:0]   cand_n;
    logic [3:0]    match_n;

    // Hysteresis slicer: between the thresholds the previous level is kept.
    always_comb begin
        level_d = level_q;
        if (sample_q >= HI_THR) begin
            level_d = 1'b1;
        end else if (sample_q <= LO_THR) begin
            level_d = 1'b0;
        end
    end

    assign edge_w    = level_d ^ level_q;
    assign glitch_w  = (cnt_q < MIN_HALF);
    assign cnt_sat_w = (cnt_q == TIMEOUT);

    // 28-bit signed difference so that neither ordering of the operands can wrap.
    assign diff_w    = $signed({1'b0, cnt_q}) - $signed({1'b0, cand_q});
    assign absdiff_w = diff_w[27] ? 28'(-diff_w) : 28'(diff_w);
    assign within_w  = (absdiff_w <= {1'b0, TOL});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_sat_w ? cnt_q : cnt_q + 27'd1;
        cand_d   = cand_q;
        match_d  = match_q;
        note_d   = note_q;
        nv_d     = 1'b0;
        locked_d = locked_q;
        cand_n   = cand_q;
        match_n  = match_q;

        case (state_q)
            IDLE: begin
                if (edge_w) begin
                    state_d = ARMED;
                    cnt_d   = 27'd1;
                end
            end

            ARMED, TRACK: begin
                if (edge_w && !glitch_w) begin
                    cnt_d = 27'd1;
                    if ((match_q == 4'd0) || !within_w) begin
                        cand_n  = cnt_q;
                        match_n = 4'd1;
                    end else begin
                        cand_n  = cand_q;
                        match_n = match_q + 4'd1;
                    end
                    cand_d = cand_n;
                    if (match_n == STABLE_W) begin
                        note_d   = cand_n;
                        nv_d     = 1'b1;
                        locked_d = 1'b1;
                        match_d  = 4'd0;
                        state_d  = TRACK;
                    end else begin
                        match_d  = match_n;
                    end
                end else if (cnt_sat_w) begin
                    state_d = IDLE;
                    match_d = 4'd0;
                    cand_d  = '0;
                    if (locked_q) begin
                        note_d   = '0;
                        locked_d = 1'b0;
                        nv_d     = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sample_q <= '0;
            level_q  <= 1'b0;
            cnt_q    <= '0;
            cand_q   <= '0;
            match_q  <= '0;
            note_q   <= '0;
            nv_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_in;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            note_q   <= note_d;
            nv_q     <= nv_d;
            locked_q <= locked_d;
        end
    end

    assign note       = note_q;
    assign note_valid = nv_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_note_period_meter.sv
// Directed bench for note_period_meter: square waves with hand-derived half-periods,
// glitch rejection, tolerance, timeout and asynchronous reset.
module tb_note_period_meter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sample_in;
    logic [26:0] note;
    logic        note_valid;
    logic        locked;

    int tests;
    int fails;
    int pulses;
    logic lvl;

    note_period_meter #(
        .HI_THR  (8'd160),
        .LO_THR  (8'd96),
        .MIN_HALF(27'd2),
        .TOL     (27'd1),
        .STABLE_N(4),
        .TIMEOUT (27'd5000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_in (sample_in),
        .note      (note),
        .note_valid(note_valid),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Flip the tone level; the new level is held for h cycles, so the next edge measures h.
    task automatic toggles(input int h);
        lvl = ~lvl;
        repeat (h) begin
            @(negedge clk);
            sample_in = lvl ? 8'd255 : 8'd0;
        end
    endtask

    // Flip the level on an edge that must publish: pulse two samples after the change.
    task automatic edge_pub(input int h, input logic [26:0] exp_note, input string tag);
        lvl = ~lvl;
        @(negedge clk);
        sample_in = lvl ? 8'd255 : 8'd0;
        @(negedge clk);
        chk({tag, "_nv_early"}, note_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_nv"}, note_valid, 1'b1);
        chk({tag, "_note"}, note, exp_note);
        chk({tag, "_locked"}, locked, 1'b1);
        repeat (h - 3) @(negedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        pulses    = 0;
        lvl       = 1'b0;
        rst_n     = 1'b0;
        sample_in = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_note", note, 27'd0);
        chk("rst_nv", note_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        rst_n = 1'b1;

        // Mid-scale input never crosses a threshold.
        repeat (300) begin
            @(negedge clk);
            sample_in = 8'd128;
        end
        #2;
        chk("steady_pulses", pulses, 0);
        chk("steady_note", note, 27'd0);
        chk("steady_locked", locked, 1'b0);
        @(negedge clk);
        sample_in = 8'd0;
        repeat (10) @(negedge clk);

        // 88-cycle square wave: publish on the 5th edge, republish every 4 edges.
        repeat (4) toggles(88);
        edge_pub(88, 27'd88, "lock88");
        #2;
        chk("lock88_pulses", pulses, 1);
        repeat (3) toggles(88);
        edge_pub(88, 27'd88, "repub88");
        #2;
        chk("repub88_pulses", pulses, 2);

        // Silence: pulse with note 0 exactly when cnt reaches TIMEOUT.
        toggles(5001);
        @(negedge clk);
        chk("to_nv_early", note_valid, 1'b0);
        chk("to_locked_before", locked, 1'b1);
        @(negedge clk);
        chk("to_nv", note_valid, 1'b1);
        chk("to_note", note, 27'd0);
        chk("to_locked", locked, 1'b0);
        @(negedge clk);
        chk("to_nv_single", note_valid, 1'b0);
        #2;
        chk("to_pulses", pulses, 3);

        // Every-cycle toggling: alternate edges are glitches, the rest measure 2 (three matches only).
        repeat (6) toggles(1);
        toggles(88);
        #2;
        chk("glitch_pulses", pulses, 3);
        chk("glitch_locked", locked, 1'b0);
        chk("glitch_note", note, 27'd0);
        repeat (3) toggles(88);
        edge_pub(88, 27'd88, "post_glitch");

        @(negedge clk);
        rst_n     = 1'b0;
        sample_in = 8'd0;
        lvl       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Tolerance: measurements 88, 89, 87, 88 stay on candidate 88.
        toggles(88);
        toggles(89);
        toggles(87);
        toggles(88);
        edge_pub(88, 27'd88, "tol");
        toggles(88);
        toggles(200);
        toggles(88);
        #2;
        chk("outlier_locked", locked, 1'b1);
        chk("outlier_note", note, 27'd88);
        // Alternating 88/90 differs by 2 each time, so every edge restarts the candidate.
        repeat (3) begin
            toggles(90);
            toggles(88);
        end
        #2;
        chk("tol2_pulses", pulses, 5);
        chk("tol2_locked", locked, 1'b1);
        chk("tol2_note", note, 27'd88);

        // Asynchronous reset while locked.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_note", note, 27'd0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_nv", note_valid, 1'b0);
        sample_in = 8'd0;
        lvl       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        chk("arst_pulses", pulses, 5);
        chk("arst_locked_after", locked, 1'b0);
        repeat (4) toggles(88);
        edge_pub(88, 27'd88, "relock");
        #2;
        chk("relock_pulses", pulses, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
